// File: rtl/mult_booth32.sv
// Iterative radix-2 Booth signed multiplier.
// One add/sub and one arithmetic shift happen per RUN cycle. Each operation takes
// exactly WIDTH RUN cycles, and then there is a single DONE cycle in which rdy pulses.
//
// Handshake: start_mult is sampled on a rising edge only in IDLE or DONE. The operands
// are captured on that same edge. rdy_mult is high for exactly one cycle (DONE), and
// out_mult/ovf_mult hold from that cycle until the next completion or reset.
// dbg_state_mult exposes the FSM state for checkers.
module mult_booth32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock_mult,
    input  logic             resetn_mult,
    input  logic             start_mult,
    input  logic [WIDTH-1:0] in1_mult,
    input  logic [WIDTH-1:0] in2_mult,
    output logic             busy_mult,
    output logic             rdy_mult,
    output logic [WIDTH-1:0] out_mult,
    output logic             ovf_mult,
    output logic [1:0]       dbg_state_mult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   r_acc;    // one extra bit so that -M of the most negative M fits
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic             r_busy;
    logic             r_rdy;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;

    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_q1_nxt;
    logic             w_ovf;
    logic             w_last;

    // One Booth step: conditional add/sub of M, then an arithmetic right shift of {ACC,Q,q_1}
    always_comb begin
        w_m_ext = {r_m[WIDTH-1], r_m};
        w_sum   = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_acc + w_m_ext;
            2'b10:   w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
        w_acc_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        w_q1_nxt  = r_q[0];
        // The product fits in {ACC[W-1:0],Q}. It fits in W bits only when the high half is all sign.
        w_ovf     = (w_acc_nxt[WIDTH-1:0] != {WIDTH{w_q_nxt[WIDTH-1]}});
        w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM and datapath registers; reset aborts any operation in progress
    always_ff @(posedge clock_mult) begin
        if (!resetn_mult) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_rdy <= 1'b0;
                    if (start_mult) begin
                        r_m     <= in1_mult;
                        r_acc   <= '0;
                        r_q     <= in2_mult;
                        r_q1    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_q1  <= w_q1_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out   <= w_q_nxt;
                        r_ovf   <= w_ovf;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_mult      = r_busy;
    assign rdy_mult       = r_rdy;
    assign out_mult       = r_out;
    assign ovf_mult       = r_ovf;
    assign dbg_state_mult = r_state;

endmodule
